uart_fpu_sequencer: RTL and testbench

//  Frame controller between the UART receiver/transmitter and the combinational FPU inside uart_conv_top.

---
 rtl/uart_fpu_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_uart_fpu_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fpu_sequencer.sv
// Purpose : frame controller between UART RX/TX and a combinational FPU; 8 bytes in, 4 bytes out.
// Latency : first result byte tx_start FPU_LATENCY+3 cycles after the 8th rx_valid (tx_busy low).
// Backpr. : waits in TX_LOAD while tx_busy is high; bytes arriving outside RX_COLLECT are dropped.
//
// Ports:
//   sys_clk, rst           clock, synchronous active-high reset
//   rx_valid, rx_byte      received byte strobe and data
//   tx_busy, tx_done       transmitter status and end-of-byte strobe
//   tx_start, tx_byte      transmit load strobe and data
//   op_sel                 FPU operation, sampled when the frame completes
//   fpu_a, fpu_b, fpu_op   operands/operation to the FPU
//   fpu_result             FPU result, captured once per frame
//   rx_status, tx_status   frame-in-progress / reply-in-progress indicators
//   rx_overrun             sticky: byte dropped because a frame was being processed
//   rx_timeout             1-cycle pulse: partial frame discarded
// Optional feature macro: RX_TIMEOUT_EN builds the RX idle timeout; otherwise
// rx_timeout is tied low and partial frames wait indefinitely.

module uart_fpu_sequencer #(
    parameter int unsigned FPU_LATENCY    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic [1:0]  op_sel,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_op,
    input  logic [31:0] fpu_result,
    output logic        rx_status,
    output logic        tx_status,
    output logic        rx_overrun,
    output logic        rx_timeout
);

    typedef enum logic [2:0] {
        S_RX_COLLECT = 3'd0,
        S_EXEC       = 3'd1,
        S_CAPTURE    = 3'd2,
        S_TX_LOAD    = 3'd3,
        S_TX_WAIT    = 3'd4
    } state_t;

    localparam int unsigned WAIT_W = (FPU_LATENCY > 1) ? $clog2(FPU_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FPU_LATENCY - 1);

    state_t            state_q, state_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [63:0]       ab_q, ab_d;          // {A, B}, shifted in MSB first
    logic [1:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]       res_q, res_d;
    logic [1:0]        tx_idx_q, tx_idx_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              overrun_q, overrun_d;
    logic              idle_expired;

    wire frame_done = (state_q == S_RX_COLLECT) && rx_valid && (byte_cnt_q == 3'd7);

`ifdef RX_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              timeout_q;

    // Counts only while a frame is partially received; any received byte
    // restarts it, so a frame completing on the expiry cycle wins.
    always_comb begin
        idle_expired = 1'b0;
        idle_cnt_d   = '0;
        if (!rx_valid && (byte_cnt_q != 3'd0)) begin
            if (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                idle_expired = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= idle_expired;
        end
    end

    assign rx_timeout = timeout_q;
`else
    // No idle counter: a partial frame waits for its remaining bytes forever.
    localparam bit TIMEOUT_CFG_NONZERO = (TIMEOUT_CYCLES != 0);

    assign idle_expired = 1'b0;
    assign rx_timeout   = TIMEOUT_CFG_NONZERO & 1'b0;
`endif

    // State register and all datapath flops.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= S_RX_COLLECT;
            byte_cnt_q <= '0;
            ab_q       <= '0;
            op_q       <= '0;
            wait_cnt_q <= '0;
            res_q      <= '0;
            tx_idx_q   <= '0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            ab_q       <= ab_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            res_q      <= res_d;
            tx_idx_q   <= tx_idx_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RX_COLLECT: if (frame_done)              state_d = S_EXEC;
            S_EXEC:       if (wait_cnt_q == WAIT_LAST) state_d = S_CAPTURE;
            S_CAPTURE:                                 state_d = S_TX_LOAD;
            S_TX_LOAD:    if (!tx_busy)                state_d = S_TX_WAIT;
            S_TX_WAIT: begin
                if (tx_done) begin
                    state_d = (tx_idx_q == 2'd3) ? S_RX_COLLECT : S_TX_LOAD;
                end
            end
            default:                                   state_d = S_RX_COLLECT;
        endcase
    end

    // Datapath and output logic.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        ab_d       = ab_q;
        op_d       = op_q;
        wait_cnt_d = wait_cnt_q;
        res_d      = res_q;
        tx_idx_d   = tx_idx_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        // Frames are never queued: anything arriving mid-frame is lost.
        overrun_d  = overrun_q | (rx_valid && (state_q != S_RX_COLLECT));

        unique case (state_q)
            S_RX_COLLECT: begin
                if (rx_valid) begin
                    ab_d       = {ab_q[55:0], rx_byte};
                    byte_cnt_d = byte_cnt_q + 3'd1;   // 7 -> 0 on the last byte
                    wait_cnt_d = '0;
                    if (byte_cnt_q == 3'd7) begin
                        op_d = op_sel;
                    end
                end else if (idle_expired) begin
                    byte_cnt_d = '0;
                    ab_d       = '0;
                end
            end
            S_EXEC: begin
                wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? '0 : wait_cnt_q + WAIT_W'(1);
            end
            S_CAPTURE: begin
                // Snapshot so later FPU input changes cannot corrupt the reply.
                res_d    = fpu_result;
                tx_idx_d = '0;
            end
            S_TX_LOAD: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    unique case (tx_idx_q)
                        2'd0:    tx_byte_d = res_q[31:24];
                        2'd1:    tx_byte_d = res_q[23:16];
                        2'd2:    tx_byte_d = res_q[15:8];
                        default: tx_byte_d = res_q[7:0];
                    endcase
                end
            end
            S_TX_WAIT: begin
                if (tx_done && (tx_idx_q != 2'd3)) begin
                    tx_idx_d = tx_idx_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    assign tx_start   = tx_start_q;
    assign tx_byte    = tx_byte_q;
    assign fpu_a      = ab_q[63:32];
    assign fpu_b      = ab_q[31:0];
    assign fpu_op     = op_q;
    assign rx_status  = (byte_cnt_q != 3'd0);
    assign tx_status  = (state_q == S_TX_LOAD) || (state_q == S_TX_WAIT);
    assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_fpu_sequencer.sv
`timescale 1ns/1ps
module tb_uart_fpu_sequencer;

    localparam int LAT = 2;
    localparam int TMO = 100;

    logic        sys_clk = 1'b0;
    logic        rst, rx_valid, tx_busy, tx_done;
    logic [7:0]  rx_byte;
    logic [1:0]  op_sel;
    logic        tx_start, rx_status, tx_status, rx_overrun, rx_timeout;
    logic [7:0]  tx_byte;
    logic [31:0] fpu_a, fpu_b, fpu_result;
    logic [1:0]  fpu_op;

    always #5 sys_clk = ~sys_clk;

    uart_fpu_sequencer #(.FPU_LATENCY(LAT), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk(sys_clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_start(tx_start), .tx_byte(tx_byte),
        .op_sel(op_sel), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
        .fpu_result(fpu_result), .rx_status(rx_status), .tx_status(tx_status),
        .rx_overrun(rx_overrun), .rx_timeout(rx_timeout)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Stand-in FPU: op 0 adds positive normal floats (truncating), others are integer ops.
    function automatic logic [31:0] fadd_pos(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] hi, lo;
        logic [7:0]  d;
        logic [23:0] ms;
        logic [24:0] sum;
        if (x[30:23] >= y[30:23]) begin hi = x; lo = y; end
        else begin hi = y; lo = x; end
        d   = hi[30:23] - lo[30:23];
        ms  = (d > 8'd24) ? 24'd0 : ({1'b1, lo[22:0]} >> d);
        sum = {2'b01, hi[22:0]} + {1'b0, ms};
        if (sum[24]) return {1'b0, hi[30:23] + 8'd1, sum[23:1]};
        return {1'b0, hi[30:23], sum[22:0]};
    endfunction

    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        case (op)
            2'd0:    return fadd_pos(a, b);
            2'd1:    return a - b;
            2'd2:    return a ^ b;
            default: return {a[15:0], b[31:16]};
        endcase
    endfunction

    // Result appears LAT cycles after the operands, so an early capture sees stale data.
    logic [65:0] pipe [LAT];
    always @(posedge sys_clk) begin
        pipe[0] <= {fpu_a, fpu_b, fpu_op};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign fpu_result = fpu_model(pipe[LAT-1][65:34], pipe[LAT-1][33:2], pipe[LAT-1][1:0]);

    typedef struct {
        logic [7:0]  b;
        int          cyc;      // required tx_start cycle, -1 when unchecked
        bit          chk_ab;
        logic [31:0] a;
        logic [31:0] bv;
        logic [1:0]  op;
    } exp_t;
    exp_t exp_q[$];

    bit chk_en = 0;
    bit chk_rx = 1;
    int m_cnt = 0;
    bit m_overrun = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int bp_at_done = -1;
    int bp_start_cyc = -1;
    int last_rx_cyc = 0;
    logic prev_busy = 1'b0;

    // Monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (chk_en) begin
                if (tx_start === 1'b1) begin
                    start_cnt++;
                    check("tx_start_while_busy", 64'(prev_busy), 64'(0));
                    check("tx_status_at_start", 64'(tx_status), 64'(1));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx_start: actual byte=%h required=no tx_start (cycle %0d)",
                                 tx_byte, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 64'(tx_byte), 64'(e.b));
                        if (e.cyc >= 0) check("first_byte_latency", 64'(cyc), 64'(e.cyc));
                        if (e.chk_ab) begin
                            check("fpu_a", 64'(fpu_a), 64'(e.a));
                            check("fpu_b", 64'(fpu_b), 64'(e.bv));
                            check("fpu_op", 64'(fpu_op), 64'(e.op));
                        end
                    end
                end
                if (cyc == bp_start_cyc) check("bp_release_start", 64'(tx_start), 64'(1));
                if (chk_rx) check("rx_status", 64'(rx_status), 64'(m_cnt != 0));
                check("rx_overrun", 64'(rx_overrun), 64'(m_overrun));
`ifndef RX_TIMEOUT_EN
                check("rx_timeout_tied", 64'(rx_timeout), 64'(0));
`endif
            end
            prev_busy = tx_busy;
        end
    end

    // UART transmitter model.
    initial begin
        int  n;
        bit  hold;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (chk_en && tx_start === 1'b1) begin
                n = $urandom_range(2, 6);
                @(posedge sys_clk); #1;
                tx_busy = 1'b1;
                repeat (n) @(posedge sys_clk);
                #1;
                tx_done = 1'b1;
                done_cnt++;
                hold = (done_cnt == bp_at_done);
                if (!hold) tx_busy = 1'b0;
                @(posedge sys_clk); #1;
                tx_done = 1'b0;
                if (hold) begin
                    repeat (500) @(posedge sys_clk);
                    #1;
                    tx_busy = 1'b0;
                    bp_start_cyc = cyc + 1;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        rx_valid = 1'b1;
        rx_byte  = b;
        last_rx_cyc = cyc;
        @(posedge sys_clk); #1;
        rx_valid = 1'b0;
        m_cnt = (m_cnt == 7) ? 0 : m_cnt + 1;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] op, input logic [31:0] res);
        logic [63:0] ab;
        exp_t e;
        ab = {a, b};
        op_sel = op;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge sys_clk);
            send_byte(ab[63-8*i -: 8]);
        end
        for (int i = 0; i < 4; i++) begin
            e.b = res[31-8*i -: 8];
            e.cyc = (i == 0) ? last_rx_cyc + LAT + 3 : -1;
            e.chk_ab = (i == 0);
            e.a = a;
            e.bv = b;
            e.op = op;
            exp_q.push_back(e);
        end
    endtask

    // Waits for the reply to drain; scrambles op_sel once TX has begun.
    task automatic wait_reply();
        int s0;
        bit ok;
        s0 = start_cnt;
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge sys_clk);
            if (start_cnt > s0) op_sel = 2'($urandom);
            if (exp_q.size() == 0 && tx_status === 1'b0 && tx_busy === 1'b0) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL reply_timeout: actual pending=%0d required pending=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_start"},   64'(tx_start),   64'(0));
        check({tag, "_tx_byte"},    64'(tx_byte),    64'(0));
        check({tag, "_fpu_a"},      64'(fpu_a),      64'(0));
        check({tag, "_fpu_b"},      64'(fpu_b),      64'(0));
        check({tag, "_fpu_op"},     64'(fpu_op),     64'(0));
        check({tag, "_rx_status"},  64'(rx_status),  64'(0));
        check({tag, "_tx_status"},  64'(tx_status),  64'(0));
        check({tag, "_rx_overrun"}, 64'(rx_overrun), 64'(0));
        check({tag, "_rx_timeout"}, 64'(rx_timeout), 64'(0));
    endtask

    function automatic logic [31:0] rand_pos_float();
        return {1'b0, 8'($urandom_range(1, 200)), 23'($urandom)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        int          target, s0;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        op_sel = 2'd0;
        repeat (3) @(posedge sys_clk);
        #1 rst = 1'b0;
        @(negedge sys_clk);
        check_reset_outputs("reset");
        chk_en = 1;

        // Float add 1.0 + 2.0 and 3.0 + 1.0, back to back.
        send_frame(32'h3F800000, 32'h40000000, 2'd0, 32'h40400000);
        wait_reply();
        send_frame(32'h40400000, 32'h3F800000, 2'd0, 32'h40800000);
        wait_reply();

        // Byte injected while the reply is being sent.
        s0 = start_cnt;
        send_frame(32'h12345678, 32'h00000078, 2'd1, 32'h12345600);
        for (int i = 0; i < 200 && start_cnt == s0; i++) @(posedge sys_clk);
        #1;
        rx_valid = 1'b1;
        rx_byte = 8'hAA;
        @(posedge sys_clk); #1;
        rx_valid = 1'b0;
        m_overrun = 1;
        wait_reply();
        send_frame(32'hA5A5A5A5, 32'h0F0F0F0F, 2'd2, 32'hAAAAAAAA);
        wait_reply();

        // Transmitter stays busy for 500 cycles after the first reply byte.
        bp_at_done = done_cnt + 1;
        a = rand_pos_float();
        b = rand_pos_float();
        send_frame(a, b, 2'd0, fpu_model(a, b, 2'd0));
        wait_reply();

        // Randomized frames.
        for (int k = 0; k < 10; k++) begin
            op = 2'($urandom_range(0, 3));
            if (op == 2'd0) begin
                a = rand_pos_float();
                b = rand_pos_float();
            end else begin
                a = $urandom;
                b = $urandom;
            end
            send_frame(a, b, op, fpu_model(a, b, op));
            wait_reply();
        end

        // Reset after the second reply byte completes; a byte on the reset cycle is dropped.
        target = done_cnt + 2;
        send_frame(32'hDEADBEEF, 32'h01020304, 2'd3, 32'hBEEF0102);
        for (int i = 0; i < 500 && done_cnt < target; i++) @(posedge sys_clk);
        #1;
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_byte = 8'h55;
        @(posedge sys_clk); #1;
        rst = 1'b0;
        rx_valid = 1'b0;
        exp_q.delete();
        m_overrun = 0;
        m_cnt = 0;
        @(negedge sys_clk);
        check_reset_outputs("midtx_reset");
        repeat (20) @(posedge sys_clk);
        #1;
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_byte = 8'h66;
        @(posedge sys_clk); #1;
        rst = 1'b0;
        rx_valid = 1'b0;
        repeat (3) @(posedge sys_clk);
        send_frame(32'h3F800000, 32'h40000000, 2'd0, 32'h40400000);
        wait_reply();

`ifdef RX_TIMEOUT_EN
        begin
            int found, c_last;
            op_sel = 2'd0;
            send_byte(8'h11);
            send_byte(8'h22);
            send_byte(8'h33);
            c_last = last_rx_cyc;
            chk_rx = 0;
            found = -1;
            for (int i = 0; i < TMO + 20 && found < 0; i++) begin
                @(negedge sys_clk);
                if (rx_timeout === 1'b1) found = cyc;
            end
            check("timeout_cycle", 64'(found), 64'(c_last + TMO + 1));
            check("timeout_rx_status", 64'(rx_status), 64'(0));
            @(negedge sys_clk);
            check("timeout_pulse_width", 64'(rx_timeout), 64'(0));
            m_cnt = 0;
            chk_rx = 1;
            send_frame(32'h3F800000, 32'h40000000, 2'd0, 32'h40400000);
            wait_reply();
        end
`endif

        repeat (10) @(posedge sys_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
